// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared defaults, clear-sequencer state type and flattened-bus
//          lane helper for the multi-read-port register file.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  // Default geometry of the datapath register file
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_LINK_REG = 31;

  // Clear sequencer states
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clrState_t;

  // Low bit index of lane 'lane' inside a flattened bus of 'width'-bit lanes
  function automatic int laneBase(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp_if
// Brief  : Decode/writeback side bundle of the register file: flattened read
//          lanes, normal and link write ports, clear request and busy.
// Rev    : 1.0  initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     lnk_en;
  logic [DATA_W-1:0]        lnk_data;
  logic                     clr_req;
  logic                     busy;

  // Datapath side: drives addresses and write data, observes read data
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, lnk_en, lnk_data, clr_req,
    input  rd_data, busy
  );

  // Register file side
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, lnk_en, lnk_data, clr_req,
    output rd_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_clear_seq.sv
`default_nettype none
// ============================================================================
// Module : regfile_clear_seq
// Brief  : Clear sequencer. Walks every entry once, one per cycle, after
//          reset or after a clear request seen while ready.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  clrState_t         r_state;
  logic [ADDR_W-1:0] r_clrPtr;

  // Sequencer FSM: single pass over the array, requests ignored mid-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CLEAR;
      r_clrPtr <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clrPtr == C_LAST) begin
            r_state  <= READY;
            r_clrPtr <= '0;
          end else begin
            r_clrPtr <= r_clrPtr + ADDR_W'(1);
          end
        end
        READY: begin
          if (clr_req) begin
            r_state  <= CLEAR;
            r_clrPtr <= '0;
          end
        end
        default: begin
          r_state  <= CLEAR;
          r_clrPtr <= '0;
        end
      endcase
    end
  end

  assign busy     = (r_state == CLEAR);
  assign clr_we   = (r_state == CLEAR);
  assign clr_addr = r_clrPtr;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp
// Brief  : Parametrised multi-read-port register file with hard-wired zero
//          register, link write port, optional write-to-read bypass and a
//          hardware clear sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int                DEPTH       = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_LINK_ADDR = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = '0;

  logic              w_busy;
  logic              w_clrWe;
  logic [ADDR_W-1:0] w_clrAddr;
  logic              w_wrCommit;
  logic              w_lnkCommit;
  logic [DATA_W-1:0] r_mem [DEPTH];

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clearSeq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .busy     (w_busy),
    .clr_we   (w_clrWe),
    .clr_addr (w_clrAddr)
  );

  assign bus.busy = w_busy;

  // Link wins a collision on LINK_REG; nothing ever lands in register 0
  assign w_lnkCommit = !w_busy && bus.lnk_en && (C_LINK_ADDR != C_ZERO_ADDR);
  assign w_wrCommit  = !w_busy && bus.wr_en && (bus.wr_addr != C_ZERO_ADDR)
                       && !(bus.lnk_en && (bus.wr_addr == C_LINK_ADDR));

  // Array write port: sequencer zeroing takes precedence over both write ports
  always_ff @(posedge clk) begin
    if (w_clrWe) begin
      r_mem[w_clrAddr] <= '0;
    end else begin
      if (w_wrCommit) begin
        r_mem[bus.wr_addr] <= bus.wr_data;
      end
      if (w_lnkCommit) begin
        r_mem[C_LINK_ADDR] <= bus.lnk_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rdLane
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = bus.rd_addr[laneBase(k, ADDR_W) +: ADDR_W];

    // Lane read mux: busy, zero register, link bypass, write bypass, array
    always_comb begin
      w_data = r_mem[w_addr];
      if (w_busy || (w_addr == C_ZERO_ADDR)) begin
        w_data = '0;
      end else if ((BYPASS != 0) && bus.lnk_en && (w_addr == C_LINK_ADDR)) begin
        w_data = bus.lnk_data;
      end else if ((BYPASS != 0) && bus.wr_en && (w_addr == bus.wr_addr)) begin
        w_data = bus.wr_data;
      end
    end

    assign bus.rd_data[laneBase(k, DATA_W) +: DATA_W] = w_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_mp
// Brief  : Self-checking bench for regfile_mp (three read lanes, bypass on).
// Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

  localparam int NRD   = 3;
  localparam int DEPTH = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(NRD)) bus ();

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (NRD),
    .LINK_REG (31),
    .BYPASS   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: array contents plus remaining busy cycles of a clear
  logic [31:0] mMem [DEPTH];
  int          mClrLeft;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        le;
    logic [31:0] ld;
    logic [4:0]  ra [NRD];
    logic [31:0] ex [NRD];
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] rdAddr(input int k);
    logic [NRD*5-1:0] flat;
    flat = bus.rd_addr;
    return flat[k*5 +: 5];
  endfunction

  function automatic logic [31:0] rdData(input int k);
    logic [NRD*32-1:0] flat;
    flat = bus.rd_data;
    return flat[k*32 +: 32];
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (mClrLeft > 0 || !rst_n) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (bus.lnk_en && a == 5'd31) return bus.lnk_data;
    if (bus.wr_en && a == bus.wr_addr) return bus.wr_data;
    return mMem[a];
  endfunction

  // Advance the model by one rising edge using the inputs currently applied
  task automatic modelEdge();
    if (!rst_n) begin
      mClrLeft = DEPTH;
    end else if (mClrLeft > 0) begin
      mMem[DEPTH - mClrLeft] = 32'h0;
      mClrLeft--;
    end else begin
      if (bus.wr_en && bus.wr_addr != 5'd0) mMem[bus.wr_addr] = bus.wr_data;
      if (bus.lnk_en) mMem[31] = bus.lnk_data;
      if (bus.clr_req) mClrLeft = DEPTH;
    end
  endtask

  task automatic chkOutputs();
    check("busy", {31'h0, bus.busy}, {31'h0, (mClrLeft > 0) || !rst_n});
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("lane%0d addr %0d", k, rdAddr(k)), rdData(k), modelRead(rdAddr(k)));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chkOutputs();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic setRd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus.rd_addr = {a2, a1, a0};
  endtask

  task automatic idleWr();
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'h0;
    bus.lnk_en  = 1'b0;
    bus.lnk_data = 32'h0;
    bus.clr_req = 1'b0;
  endtask

  task automatic randomWr();
    bus.wr_en    = $urandom_range(0, 1) == 1;
    bus.wr_addr  = 5'($urandom_range(0, 31));
    bus.wr_data  = $urandom;
    bus.lnk_en   = $urandom_range(0, 3) == 0;
    bus.lnk_data = $urandom;
  endtask

  task automatic randomRd();
    setRd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 2) == 0) ? bus.wr_addr : 5'($urandom_range(0, 31)));
  endtask

  // Count busy cycles of a clear that is starting; the loop is bounded
  task automatic measureClear(input string name, input bit noisy);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (noisy) randomWr(); else idleWr();
      randomRd();
      @(negedge clk);
      chkOutputs();
      if (bus.busy) n++; else seen = 1'b1;
      modelEdge();
      @(posedge clk);
      #1;
    end
    check({name, " busy_cycles"}, n, DEPTH);
    check({name, " ready_seen"}, {31'h0, seen}, 32'h1);
    idleWr();
  endtask

  task automatic sweepAll();
    idleWr();
    for (int a = 0; a < DEPTH; a += NRD) begin
      setRd(5'(a), 5'((a + 1) % DEPTH), 5'((a + 2) % DEPTH));
      cycle();
    end
  endtask

  task automatic addVec(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic le, input logic [31:0] ld,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.le = le; v.ld = ld;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2;
    vq.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = 32'h0;
    idleWr();
    setRd(5'd0, 5'd1, 5'd31);

    // Power-on reset and initial clear
    rst_n = 1'b0;
    mClrLeft = DEPTH;
    repeat (2) cycle();
    rst_n = 1'b1;
    measureClear("reset_clear", 1'b0);
    sweepAll();

    // Directed vectors against hand-derived expectations
    //      we  wa     wd            le  ld            r0     r1     r2     e0            e1            e2
    addVec(1, 5'd5,  32'hDEADBEEF, 0, 32'h0,        5'd5,  5'd0,  5'd6,  32'hDEADBEEF, 32'h0,        32'h0);
    addVec(0, 5'd0,  32'h0,        0, 32'h0,        5'd5,  5'd5,  5'd1,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    addVec(1, 5'd0,  32'h12345678, 0, 32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0);
    addVec(0, 5'd0,  32'h0,        0, 32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0);
    addVec(1, 5'd31, 32'h1111,     1, 32'h2222,     5'd31, 5'd5,  5'd0,  32'h2222,     32'hDEADBEEF, 32'h0);
    addVec(0, 5'd0,  32'h0,        0, 32'h0,        5'd31, 5'd31, 5'd5,  32'h2222,     32'h2222,     32'hDEADBEEF);
    addVec(1, 5'd7,  32'h3333,     1, 32'h4444,     5'd7,  5'd31, 5'd6,  32'h3333,     32'h4444,     32'h0);
    addVec(0, 5'd0,  32'h0,        0, 32'h0,        5'd7,  5'd31, 5'd1,  32'h3333,     32'h4444,     32'h0);
    addVec(1, 5'd5,  32'h55,       0, 32'h0,        5'd5,  5'd7,  5'd31, 32'h55,       32'h3333,     32'h4444);
    addVec(0, 5'd0,  32'h0,        0, 32'h0,        5'd5,  5'd0,  5'd7,  32'h55,       32'h0,        32'h3333);
    addVec(0, 5'd0,  32'h0,        1, 32'hAAAA,     5'd31, 5'd30, 5'd7,  32'hAAAA,     32'h0,        32'h3333);
    addVec(0, 5'd0,  32'h0,        0, 32'h0,        5'd31, 5'd30, 5'd5,  32'hAAAA,     32'h0,        32'h55);

    for (int i = 0; i < vq.size(); i++) begin
      bus.wr_en = vq[i].we; bus.wr_addr = vq[i].wa; bus.wr_data = vq[i].wd;
      bus.lnk_en = vq[i].le; bus.lnk_data = vq[i].ld; bus.clr_req = 1'b0;
      setRd(vq[i].ra[0], vq[i].ra[1], vq[i].ra[2]);
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("vec%0d lane%0d", i, k), rdData(k), vq[i].ex[k]);
      end
      modelEdge();
      @(posedge clk);
      #1;
    end
    idleWr();

    // Soft clear: fill r1..r31 with their index, request clear, write during busy
    for (int a = 1; a < DEPTH; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_data = 32'(a);
      setRd(5'(a), 5'(a - 1), 5'd0);
      cycle();
    end
    idleWr();
    bus.clr_req = 1'b1;
    setRd(5'd3, 5'd17, 5'd31);
    cycle();
    bus.clr_req = 1'b0;
    measureClear("soft_clear", 1'b1);
    sweepAll();

    // Reset in the middle of a clear restarts the full sequence
    bus.clr_req = 1'b1;
    cycle();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      randomRd();
      bus.clr_req = 1'b1;   // ignored while clearing
      cycle();
    end
    bus.clr_req = 1'b0;
    rst_n = 1'b0;
    mClrLeft = DEPTH;
    repeat (2) cycle();
    rst_n = 1'b1;
    measureClear("mid_clear_reset", 1'b1);
    sweepAll();

    // Randomised traffic against the model, with occasional clear requests
    for (int i = 0; i < 600; i++) begin
      randomWr();
      bus.clr_req = $urandom_range(0, 149) == 0;
      randomRd();
      cycle();
    end
    idleWr();
    sweepAll();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
